ahb_generic_bus_bridge: RTL and testbench
=========================================

AHB_GENERIC_BUS_BRIDGE -- requirements
Module: ahb_generic_bus_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of HADDR and gbif.addr.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of HWDATA/HRDATA and gbif data; only 32 is supported.
REQ-003 SHALL have ports, one clock, reset asynchronous active-low:
 clk  in  1  sole clock, rising edge
 reset  in  1  asynchronous, active-low reset
 HSEL  in  1  slave select
 HADDR  in  ADDR_WIDTH  AHB byte address
 HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
 HWRITE  in  1  1=write
 HSIZE  in  3  0=byte, 1=half, 2=word
 HWDATA  in  DATA_WIDTH  write data, data phase
 HREADY  in  1  bus-wide ready
 HREADYOUT  out  1  slave ready
 HRESP  out  1  0=OKAY, 1=ERROR
 HRDATA  out  DATA_WIDTH  read data
 gbif  generic_bus_if.cpu  -  addr, ren, wen, wdata, byte_en out; rdata, busy in

Function
REQ-004 SHALL capture the address phase (HADDR, HWRITE, HSIZE) into registers only when HSEL & HTRANS[1] & HREADY are all 1; IDLE/BUSY transfers are not captured and receive zero-wait OKAY.
REQ-005 SHALL implement FSM states IDLE, ACCESS, ERR1, ERR2; reset state IDLE.
REQ-006 IDLE -> ACCESS on a valid capture of an aligned transfer; IDLE -> ERR1 on a valid capture of a faulting transfer.
REQ-007 In ACCESS, gbif.addr SHALL be the captured address with bits [1:0] forced to 0; gbif.ren = ~write; gbif.wen = write; gbif.wdata = HWDATA (pass-through).
REQ-008 gbif.byte_en SHALL be: byte -> 4'b0001 << addr[1:0]; half -> 4'b0011 << addr[1:0]; word -> 4'b1111.
REQ-009 In ACCESS, HREADYOUT SHALL equal ~gbif.busy; HRDATA SHALL equal gbif.rdata while HREADYOUT = 1, else 0.
REQ-010 ACCESS completes in the cycle gbif.busy = 0, giving zero wait states if busy is low in the first data-phase cycle; each busy cycle adds exactly one wait state.
REQ-011 On completion, if a new valid capture occurs in the same cycle (pipelined back-to-back), the FSM SHALL go to ACCESS/ERR1 for it; otherwise it SHALL go to IDLE.
REQ-012 gbif.ren/wen SHALL be 0 outside ACCESS; no bus access SHALL be issued for faulting transfers.
REQ-013 ERR1: HREADYOUT = 0, HRESP = 1; ERR2: HREADYOUT = 1, HRESP = 1; ERR1 -> ERR2 -> IDLE, or from ERR2 straight to ACCESS/ERR1 on a new capture.
REQ-014 A fault SHALL be: HSIZE > 2, half with addr[0] = 1, or word with addr[1:0] != 0.
REQ-015 HRESP SHALL be 0 in IDLE and ACCESS; HRDATA SHALL be 0 in IDLE and ERR states.

Reset
REQ-016 Asserting reset (low) SHALL immediately force: state IDLE, captured registers 0, HREADYOUT = 1, HRESP = 0, HRDATA = 0, gbif.ren = gbif.wen = 0, gbif.byte_en = 0, gbif.addr = 0.
REQ-017 Reset asserted mid-ACCESS SHALL abort the access with no further gbif strobe; the first capture after deassertion SHALL be accepted normally.

Configuration
REQ-018 Macro AHB_BRIDGE_ERR_CHECK_EN: when defined, REQ-013/REQ-014 apply. When undefined, no transfer faults, ERR1/ERR2 are not built, HRESP is tied 0, and misaligned addresses are issued with the REQ-008 byte_en.

Structure
REQ-019 Package ahb_bridge_pkg SHALL hold the htrans_t and hsize_t enums and the bridge_state_t enum, plus the constants HTRANS_NONSEQ, HSIZE_WORD, etc.
REQ-020 Byte-enable generation and fault detection SHALL be in a combinational sub-module ahb_byte_en_dec (inputs size and addr[1:0]; outputs byte_en and fault).
REQ-021 The generic_bus_if interface SHALL be reused unchanged.

Verification
REQ-022 Write NONSEQ word 0x0000_0004, HWDATA 0x1, busy = 0 -> one data cycle: wen = 1, addr 0x4, byte_en 1111, HREADYOUT = 1.
REQ-023 Read word 0x0000_0008, busy high for 3 cycles, rdata 0xA5 -> 3 cycles with HREADYOUT = 0, then HRDATA = 0xA5 with HREADYOUT = 1.
REQ-024 Byte write at 0x0000_0006 -> byte_en 0100, addr 0x4; half read at 0x2 -> byte_en 1100.
REQ-025 Word write at 0x0000_0005 (ERR_CHECK_EN defined) -> HRESP = 1 for 2 cycles (HREADYOUT 0 then 1), wen never 1; with the macro undefined -> wen = 1, byte_en 1111.
REQ-026 Back-to-back NONSEQ write 0x4 then read 0x8, busy = 0 -> two consecutive ACCESS cycles, no IDLE between them.
REQ-027 Reset pulled low during a busy read -> ren drops the same cycle, HREADYOUT = 1; the next write after release completes normally.

Source files
------------

// File: rtl/ahb_bridge_pkg.sv
// Shared AHB encodings, lane count and FSM state type for the AHB-to-generic-bus bridge.
package ahb_bridge_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ERR1   = 2'd2,
        ST_ERR2   = 2'd3
    } bridge_state_t;

    localparam int BYTE_LANES = 4;

endpackage

// File: rtl/generic_bus_if.sv
// Simple synchronous generic bus: one strobe per access, slave stalls with busy.
interface generic_bus_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    ren;
    logic                    wen;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] byte_en;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    busy;

    modport cpu (output addr, ren, wen, wdata, byte_en, input rdata, busy);
    modport mem (input addr, ren, wen, wdata, byte_en, output rdata, busy);
endinterface

// File: rtl/ahb_byte_en_dec.sv
// Byte-lane decode and size/alignment fault detection for one AHB address phase.
// Faults are reported only when AHB_BRIDGE_ERR_CHECK_EN is defined.
module ahb_byte_en_dec
    import ahb_bridge_pkg::*;
(
    input  logic [2:0]            size_i,
    input  logic [1:0]            addr_i,
    output logic [BYTE_LANES-1:0] byte_en_o,
    output logic                  fault_o
);

`ifdef AHB_BRIDGE_ERR_CHECK_EN
    localparam logic ERR_CHECK_EN = 1'b1;
`else
    localparam logic ERR_CHECK_EN = 1'b0;
`endif

    logic bad_xfer_s;

    // Lane mask from size and low address bits; oversize transfers fall back to a full word.
    always_comb begin
        byte_en_o  = 4'b0000;
        bad_xfer_s = 1'b0;
        case (size_i)
            HSIZE_BYTE: begin
                byte_en_o  = 4'b0001 << addr_i;
                bad_xfer_s = 1'b0;
            end
            HSIZE_HALF: begin
                byte_en_o  = 4'b0011 << addr_i;
                bad_xfer_s = addr_i[0];
            end
            HSIZE_WORD: begin
                byte_en_o  = 4'b1111;
                bad_xfer_s = (addr_i != 2'b00);
            end
            default: begin
                byte_en_o  = 4'b1111;
                bad_xfer_s = 1'b1;
            end
        endcase
    end

    assign fault_o = ERR_CHECK_EN & bad_xfer_s;

endmodule

// File: rtl/ahb_generic_bus_bridge.sv
// AHB-Lite slave that turns each NONSEQ/SEQ transfer into one generic_bus_if access.
// Define AHB_BRIDGE_ERR_CHECK_EN to build the two-cycle ERROR response for bad transfers.
module ahb_generic_bus_bridge
    import ahb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA,
    generic_bus_if.cpu            gbif
);

    bridge_state_t         state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [BYTE_LANES-1:0] byte_en_q;

    logic [BYTE_LANES-1:0] dec_byte_en_s;
    logic                  dec_fault_s;
    logic                  valid_s;
    logic                  accept_s;
    logic                  capture_s;
    bridge_state_t         launch_state_d;

    ahb_byte_en_dec u_byte_en_dec (
        .size_i    (HSIZE),
        .addr_i    (HADDR[1:0]),
        .byte_en_o (dec_byte_en_s),
        .fault_o   (dec_fault_s)
    );

    // Qualify the address phase and pick the state a captured transfer launches into.
    always_comb begin
        valid_s = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
        case (state_q)
            ST_IDLE:   accept_s = 1'b1;
            ST_ACCESS: accept_s = ~gbif.busy;
            ST_ERR2:   accept_s = 1'b1;
            default:   accept_s = 1'b0;
        endcase
        capture_s = valid_s & accept_s;
        if (!capture_s) begin
            launch_state_d = ST_IDLE;
        end else if (dec_fault_s) begin
            launch_state_d = ST_ERR1;
        end else begin
            launch_state_d = ST_ACCESS;
        end
    end

    // Bridge FSM plus the captured address phase (address stored word-aligned).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= {ADDR_WIDTH{1'b0}};
            write_q   <= 1'b0;
            byte_en_q <= {BYTE_LANES{1'b0}};
        end else begin
            if (capture_s) begin
                addr_q    <= {HADDR[ADDR_WIDTH-1:2], 2'b00};
                write_q   <= HWRITE;
                byte_en_q <= dec_byte_en_s;
            end
            case (state_q)
                ST_IDLE: state_q <= launch_state_d;
                ST_ACCESS: begin
                    if (!gbif.busy) begin
                        state_q <= launch_state_d;
                    end else begin
                        state_q <= ST_ACCESS;
                    end
                end
`ifdef AHB_BRIDGE_ERR_CHECK_EN
                ST_ERR1: state_q <= ST_ERR2;
                ST_ERR2: state_q <= launch_state_d;
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Strobes only exist in ACCESS; the slave's busy directly stretches the AHB data phase.
    always_comb begin
        gbif.wdata = HWDATA;
        if (state_q == ST_ACCESS) begin
            gbif.addr    = addr_q;
            gbif.ren     = ~write_q;
            gbif.wen     = write_q;
            gbif.byte_en = byte_en_q;
            HREADYOUT    = ~gbif.busy;
            HRDATA       = gbif.busy ? {DATA_WIDTH{1'b0}} : gbif.rdata;
        end else begin
            gbif.addr    = {ADDR_WIDTH{1'b0}};
            gbif.ren     = 1'b0;
            gbif.wen     = 1'b0;
            gbif.byte_en = {BYTE_LANES{1'b0}};
            HREADYOUT    = (state_q != ST_ERR1);
            HRDATA       = {DATA_WIDTH{1'b0}};
        end
    end

`ifdef AHB_BRIDGE_ERR_CHECK_EN
    assign HRESP = (state_q == ST_ERR1) | (state_q == ST_ERR2);
`else
    assign HRESP = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_generic_bus_bridge.sv
// Self-checking bench: directed vector table, corner-case sequences and random
// transfers checked against a transaction-level model of the bridge.
module tb_ahb_generic_bus_bridge;

`ifdef AHB_BRIDGE_ERR_CHECK_EN
    localparam bit ERR_CHECK = 1'b1;
`else
    localparam bit ERR_CHECK = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        write;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          busy;
        logic [3:0]  exp_be;
        logic        fault;
    } xfer_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    bit          hready_block;

    int checks = 0;
    int errors = 0;
    xfer_t pend[$];
    xfer_t tbl[9];
    int ncyc;

    generic_bus_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) gbif ();

    ahb_generic_bus_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .gbif      (gbif)
    );

    assign HREADY = HREADYOUT & ~hready_block;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    function automatic logic [3:0] model_be(input logic [31:0] addr, input logic [2:0] size);
        int off;
        int v;
        off = int'(addr % 32'd4);
        if (size == 3'd0) v = (1 << off) & 15;
        else if (size == 3'd1) v = (3 << off) & 15;
        else v = 15;
        return v[3:0];
    endfunction

    function automatic logic model_fault(input logic [31:0] addr, input logic [2:0] size);
        return (size > 3'd2) || (size == 3'd1 && addr % 32'd2 != 32'd0) ||
               (size == 3'd2 && addr % 32'd4 != 32'd0);
    endfunction

    function automatic xfer_t rand_xfer();
        xfer_t t;
        t.size  = ERR_CHECK ? 3'($urandom_range(3, 0)) : 3'($urandom_range(2, 0));
        t.addr  = $urandom & 32'h0000_0FFF;
        if ($urandom_range(1, 0) == 1) begin
            if (t.size == 3'd2) t.addr = t.addr & ~32'd3;
            if (t.size == 3'd1) t.addr = t.addr & ~32'd1;
        end
        t.write  = 1'($urandom_range(1, 0));
        t.wdata  = $urandom;
        t.rdata  = $urandom;
        t.busy   = $urandom_range(3, 0);
        t.exp_be = model_be(t.addr, t.size);
        t.fault  = model_fault(t.addr, t.size);
        return t;
    endfunction

    // Plays the queued transfers as a pipelined AHB master with a model-driven slave;
    // starts and ends just after a rising edge.
    task automatic run_seq(input int gap_max, output int cyc);
        xfer_t dp;
        xfer_t nx;
        bit dp_v, issue, er, fe;
        int k, gap;
        dp_v = 1'b0;
        k = 0;
        cyc = 0;
        gap = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
        while ((pend.size() != 0 || dp_v) && cyc < 4000) begin
            issue = (pend.size() != 0) && (gap == 0);
            if (issue) begin
                nx = pend[0];
                HSEL = 1'b1; HTRANS = 2'd2; HADDR = nx.addr; HWRITE = nx.write; HSIZE = nx.size;
            end else begin
                HSEL = 1'($urandom_range(1, 0)); HTRANS = 2'($urandom_range(1, 0));
                HADDR = $urandom; HWRITE = 1'($urandom_range(1, 0)); HSIZE = 3'($urandom_range(2, 0));
            end
            fe = dp_v && dp.fault && ERR_CHECK;
            if (dp_v) begin
                HWDATA = dp.wdata; gbif.rdata = dp.rdata; gbif.busy = !fe && (k < dp.busy);
            end else begin
                HWDATA = $urandom; gbif.rdata = $urandom; gbif.busy = 1'($urandom_range(1, 0));
            end
            @(negedge clk);
            if (!dp_v) begin
                er = 1'b1;
                chk("idle_ren", 32'(gbif.ren), 32'd0);
                chk("idle_wen", 32'(gbif.wen), 32'd0);
                chk("idle_be", 32'(gbif.byte_en), 32'd0);
                chk("idle_hresp", 32'(HRESP), 32'd0);
                chk("idle_hrdata", HRDATA, 32'd0);
            end else if (fe) begin
                er = (k == 1);
                chk("err_ren", 32'(gbif.ren), 32'd0);
                chk("err_wen", 32'(gbif.wen), 32'd0);
                chk("err_hresp", 32'(HRESP), 32'd1);
                chk("err_hrdata", HRDATA, 32'd0);
            end else begin
                er = (k >= dp.busy);
                chk("acc_ren", 32'(gbif.ren), 32'(!dp.write));
                chk("acc_wen", 32'(gbif.wen), 32'(dp.write));
                chk("acc_addr", gbif.addr, dp.addr & ~32'd3);
                chk("acc_be", 32'(gbif.byte_en), 32'(dp.exp_be));
                chk("acc_wdata", gbif.wdata, dp.wdata);
                chk("acc_hresp", 32'(HRESP), 32'd0);
                chk("acc_hrdata", HRDATA, er ? dp.rdata : 32'd0);
            end
            chk("hreadyout", 32'(HREADYOUT), 32'(er));
            @(posedge clk);
            #1;
            cyc++;
            if (!issue && gap > 0) gap--;
            if (er) begin
                dp_v = issue;
                k = 0;
                if (issue) begin
                    dp = pend.pop_front();
                    gap = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
                end
            end else begin
                k++;
            end
        end
        chk("seq_drained", 32'(pend.size()) + 32'(dp_v), 32'd0);
        pend.delete();
        HSEL = 1'b0; HTRANS = 2'd0; gbif.busy = 1'b0;
    endtask

    // One address phase that must not be captured, then confirm no access follows.
    task automatic probe_no_capture(input string name, input logic sel, input logic [1:0] tr, input bit blk);
        HSEL = sel; HTRANS = tr; HADDR = 32'h10; HWRITE = 1'b1; HSIZE = 3'd2;
        hready_block = blk; gbif.busy = 1'b0;
        @(negedge clk);
        chk({name, "_okay"}, 32'(HRESP), 32'd0);
        @(posedge clk);
        #1;
        HSEL = 1'b0; HTRANS = 2'd0; hready_block = 1'b0;
        @(negedge clk);
        chk({name, "_strobe"}, 32'({gbif.ren, gbif.wen}), 32'd0);
        chk({name, "_ready"}, 32'(HREADYOUT), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // addr, size, write, wdata, rdata, busy, expected byte_en, faulting
        tbl[0] = '{32'h0000_0004, 3'd2, 1'b1, 32'h0000_0001, 32'h0,          0, 4'b1111, 1'b0};
        tbl[1] = '{32'h0000_0008, 3'd2, 1'b0, 32'h0,          32'h0000_00A5, 3, 4'b1111, 1'b0};
        tbl[2] = '{32'h0000_0006, 3'd0, 1'b1, 32'h0000_0077, 32'h0,          0, 4'b0100, 1'b0};
        tbl[3] = '{32'h0000_0002, 3'd1, 1'b0, 32'h0,          32'h1234_5678, 0, 4'b1100, 1'b0};
        tbl[4] = '{32'h0000_0005, 3'd2, 1'b1, 32'hDEAD_BEEF, 32'h0,          0, 4'b1111, 1'b1};
        tbl[5] = '{32'h0000_0003, 3'd0, 1'b0, 32'h0,          32'h0BAD_F00D, 1, 4'b1000, 1'b0};
        tbl[6] = '{32'h0000_0001, 3'd1, 1'b1, 32'h0000_5555, 32'h0,          0, 4'b0110, 1'b1};
        tbl[7] = '{32'h0000_0000, 3'd1, 1'b1, 32'hCAFE_0000, 32'h0,          1, 4'b0011, 1'b0};
        tbl[8] = '{32'h0000_0101, 3'd0, 1'b0, 32'h0,          32'h0000_0042, 2, 4'b0010, 1'b0};

        reset = 1'b1; HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'd0; HWRITE = 1'b0; HSIZE = 3'd0;
        HWDATA = 32'h0; hready_block = 1'b0; gbif.busy = 1'b0; gbif.rdata = 32'h0;
        #1 reset = 1'b0;
        #1;
        chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("rst_hresp", 32'(HRESP), 32'd0);
        chk("rst_hrdata", HRDATA, 32'd0);
        chk("rst_ren_wen", 32'({gbif.ren, gbif.wen}), 32'd0);
        chk("rst_be", 32'(gbif.byte_en), 32'd0);
        chk("rst_addr", gbif.addr, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            pend.push_back(tbl[i]);
            run_seq(0, ncyc);
        end

        // back-to-back write then read with no idle between data phases
        pend.push_back(tbl[0]);
        pend.push_back('{32'h0000_0008, 3'd2, 1'b0, 32'h0, 32'h0000_3C3C, 0, 4'b1111, 1'b0});
        run_seq(0, ncyc);
        // back-to-back through an error response
        pend.push_back(tbl[4]);
        pend.push_back(tbl[2]);
        pend.push_back(tbl[1]);
        run_seq(0, ncyc);

        probe_no_capture("htrans_busy", 1'b1, 2'd1, 1'b0);
        probe_no_capture("htrans_idle", 1'b1, 2'd0, 1'b0);
        probe_no_capture("hsel_low", 1'b0, 2'd2, 1'b0);
        probe_no_capture("hready_low", 1'b1, 2'd2, 1'b1);

        for (int r = 0; r < 6; r++) begin
            for (int n = 0; n < 25; n++) pend.push_back(rand_xfer());
            run_seq(r % 3, ncyc);
        end

        // reset during a stalled read
        HSEL = 1'b1; HTRANS = 2'd2; HADDR = 32'h8; HWRITE = 1'b0; HSIZE = 3'd2; gbif.busy = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        HSEL = 1'b0; HTRANS = 2'd0;
        @(negedge clk);
        chk("abort_pre_ren", 32'(gbif.ren), 32'd1);
        chk("abort_pre_ready", 32'(HREADYOUT), 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("abort_ren", 32'(gbif.ren), 32'd0);
        chk("abort_ready", 32'(HREADYOUT), 32'd1);
        chk("abort_addr", gbif.addr, 32'd0);
        chk("abort_be", 32'(gbif.byte_en), 32'd0);
        chk("abort_hrdata", HRDATA, 32'd0);
        @(posedge clk);
        #3 reset = 1'b1;
        gbif.busy = 1'b0;
        @(negedge clk);
        chk("abort_no_strobe", 32'({gbif.ren, gbif.wen}), 32'd0);
        @(posedge clk);
        #1;
        pend.push_back('{32'h0000_0010, 3'd2, 1'b1, 32'h0000_ABCD, 32'h0, 0, 4'b1111, 1'b0});
        run_seq(0, ncyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
